// File: rtl/lights_out_game.sv
// Lights Out puzzle: LFSR-driven scramble, then player presses toggle a cell and its orthogonal neighbours.
// Latency: a press or undo updates grid/moves at the next rising edge; status outputs decode the registered state.
// Backpressure: none; presses are sampled every cycle and dropped outside PLAY. Optional undo: LIGHTS_OUT_UNDO_EN.
//
// Ports: clk, reset (async active-low), start, press_valid/press_row/press_col, undo,
//        grid (bit r*N+c), moves, solved, busy, out (ASCII status).
module lights_out_game #(
    parameter int          N              = 5,
    parameter int          SCRAMBLE_MOVES = 16,
    parameter int          MOVE_W         = 8,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              press_valid,
    input  logic [2:0]        press_row,
    input  logic [2:0]        press_col,
    input  logic              undo,
    output logic [N*N-1:0]    grid,
    output logic [MOVE_W-1:0] moves,
    output logic              solved,
    output logic              busy,
    output logic [7:0]        out
);

    localparam int          NN       = N * N;
    localparam logic [7:0]  SCR_LOAD = 8'(SCRAMBLE_MOVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCRAMBLE,
        S_PLAY,
        S_WON
    } state_t;

    state_t              state_q, state_d;
    logic [NN-1:0]       grid_q, grid_d;
    logic [MOVE_W-1:0]   moves_q, moves_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [7:0]          scr_cnt_q, scr_cnt_d;

    logic [NN-1:0]       scr_mask;
    logic [NN-1:0]       press_mask;
    logic                press_in_range;
    int                  scr_idx;

    // Toggle pattern for a press at (r,c); no wrap-around at the grid edges.
    function automatic logic [NN-1:0] cell_mask(input int r, input int c);
        logic [NN-1:0] m;
        m = '0;
        for (int k = 0; k < NN; k++) begin
            int i;
            int j;
            i = k / N;
            j = k % N;
            if ((i == r && (j == c || j == c - 1 || j == c + 1)) ||
                (j == c && (i == r - 1 || i == r + 1)))
                m[k] = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        scr_idx        = int'(lfsr_q) % NN;
        scr_mask       = cell_mask(scr_idx / N, scr_idx % N);
        press_mask     = cell_mask(int'(press_row), int'(press_col));
        press_in_range = (int'(press_row) < N) && (int'(press_col) < N);
    end

`ifdef LIGHTS_OUT_UNDO_EN
    logic [2:0]    hist_row_q, hist_row_d;
    logic [2:0]    hist_col_q, hist_col_d;
    logic          hist_vld_q, hist_vld_d;
    logic [NN-1:0] undo_mask;

    always_comb begin
        undo_mask = cell_mask(int'(hist_row_q), int'(hist_col_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_row_q <= '0;
            hist_col_q <= '0;
            hist_vld_q <= 1'b0;
        end else begin
            hist_row_q <= hist_row_d;
            hist_col_q <= hist_col_d;
            hist_vld_q <= hist_vld_d;
        end
    end
`else
    logic unused_undo;
    assign unused_undo = undo;
`endif

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        moves_d   = moves_q;
        scr_cnt_d = scr_cnt_q;
        // Fibonacci taps 16,14,13,11; free-running in every state.
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef LIGHTS_OUT_UNDO_EN
        hist_row_d = hist_row_q;
        hist_col_d = hist_col_q;
        hist_vld_d = hist_vld_q;
`endif
        if (start) begin
            // start overrides everything, including a same-cycle press
            state_d   = S_SCRAMBLE;
            grid_d    = '0;
            moves_d   = '0;
            scr_cnt_d = SCR_LOAD;
`ifdef LIGHTS_OUT_UNDO_EN
            hist_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_SCRAMBLE: begin
                    grid_d = grid_q ^ scr_mask;
                    if (scr_cnt_q > 8'd1) begin
                        scr_cnt_d = scr_cnt_q - 8'd1;
                    end else begin
                        // Last counted press (or an extra one): leave only once something is lit.
                        scr_cnt_d = '0;
                        if (grid_d != '0)
                            state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (press_valid) begin
                        if (press_in_range) begin
                            grid_d = grid_q ^ press_mask;
                            if (moves_q != '1)
                                moves_d = moves_q + 1'b1;
                            if (grid_d == '0)
                                state_d = S_WON;
`ifdef LIGHTS_OUT_UNDO_EN
                            hist_row_d = press_row;
                            hist_col_d = press_col;
                            hist_vld_d = 1'b1;
`endif
                        end
                    end
`ifdef LIGHTS_OUT_UNDO_EN
                    else if (undo && hist_vld_q) begin
                        // A press is its own inverse, so undo re-applies it.
                        grid_d     = grid_q ^ undo_mask;
                        hist_vld_d = 1'b0;
                        if (moves_q != '0)
                            moves_d = moves_q - 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grid_q    <= '0;
            moves_q   <= '0;
            lfsr_q    <= SEED;
            scr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            moves_q   <= moves_d;
            lfsr_q    <= lfsr_d;
            scr_cnt_q <= scr_cnt_d;
        end
    end

    assign grid   = grid_q;
    assign moves  = moves_q;
    assign solved = (state_q == S_WON);
    assign busy   = (state_q == S_SCRAMBLE);

    always_comb begin
        case (state_q)
            S_SCRAMBLE: out = "S";
            S_PLAY:     out = "P";
            S_WON:      out = "W";
            default:    out = "I";
        endcase
    end

endmodule
